// File: rtl/knn_vote_pkg.sv
`default_nettype none
// ============================================================================
//  knn_vote_pkg
//  Shared kNN definitions: entry layout, empty-slot sentinel, vote FSM states.
//  Revision: 1.0
// ============================================================================
package knn_vote_pkg;

   localparam int KNN_DATA_INFO = 40;
   localparam int KNN_LABEL_W   = 8;
   localparam int KNN_LABEL_LSB = 0;
   localparam int KNN_DIST_LSB  = 8;
   localparam int KNN_DIST_W    = 32;

   // An insert stage marks an unused neighbour slot with an all-ones distance.
   localparam logic [KNN_DIST_W-1:0] KNN_EMPTY_DIST = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } vote_state_e;

endpackage
`default_nettype wire

// File: rtl/knn_vote_count.sv
`default_nettype none
// ============================================================================
//  knn_vote_count
//  Counts valid snapshot entries whose label matches the label at idx.
//  Revision: 1.0
// ============================================================================
module knn_vote_count
   import knn_vote_pkg::*;
#(
   parameter int K         = 4,
   parameter int DATA_INFO = KNN_DATA_INFO,
   parameter int LABEL_W   = KNN_LABEL_W,
   parameter int CNT_W     = $clog2(K + 1),
   parameter int IDX_W     = (K > 1) ? $clog2(K) : 1
) (
   input  logic [K*DATA_INFO-1:0] snap,
   input  logic [IDX_W-1:0]       idx,
   output logic [CNT_W-1:0]       cnt
);

   logic [LABEL_W-1:0] ref_label;

   always_comb begin
      ref_label = snap[int'(idx) * DATA_INFO + KNN_LABEL_LSB +: LABEL_W];
      cnt       = '0;
      for (int j = 0; j < K; j++) begin
         if ((snap[j * DATA_INFO + KNN_DIST_LSB +: KNN_DIST_W] != KNN_EMPTY_DIST) &&
             (snap[j * DATA_INFO + KNN_LABEL_LSB +: LABEL_W] == ref_label)) begin
            cnt = cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
//  knn_vote
//  Majority vote over a captured kNN neighbour list; ties go to the nearer entry.
//  Revision: 1.0
// ============================================================================
module knn_vote
   import knn_vote_pkg::*;
#(
   parameter int K         = 4,
   parameter int DATA_INFO = KNN_DATA_INFO,
   parameter int LABEL_W   = KNN_LABEL_W,
   parameter int CNT_W     = $clog2(K + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [K*DATA_INFO-1:0] nb_list,
   input  logic                   start,
   input  logic                   ack,
   output logic                   busy,
   output logic                   out_valid,
   output logic [LABEL_W-1:0]     class_label,
   output logic [CNT_W-1:0]       votes,
   output logic                   empty
);

   localparam int               IDX_W    = (K > 1) ? $clog2(K) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   vote_state_e            state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [K*DATA_INFO-1:0] snap_q, snap_d;

   // Stage-1 registers hold the evaluation of one index; the compare happens a cycle later.
   logic                   eval_vld_q, eval_vld_d;
   logic                   eval_last_q, eval_last_d;
   logic                   eval_ok_q, eval_ok_d;
   logic [CNT_W-1:0]       eval_cnt_q, eval_cnt_d;
   logic [KNN_DIST_W-1:0]  eval_dist_q, eval_dist_d;
   logic [LABEL_W-1:0]     eval_label_q, eval_label_d;

   logic [CNT_W-1:0]       best_cnt_q, best_cnt_d;
   logic [KNN_DIST_W-1:0]  best_dist_q, best_dist_d;
   logic [LABEL_W-1:0]     best_label_q, best_label_d;

   logic                   busy_q, busy_d;
   logic                   out_valid_q, out_valid_d;
   logic [LABEL_W-1:0]     class_label_q, class_label_d;
   logic [CNT_W-1:0]       votes_q, votes_d;
   logic                   empty_q, empty_d;

   logic [CNT_W-1:0]       idx_cnt;
   logic [DATA_INFO-1:0]   cur_entry;
   logic                   take;
   logic [CNT_W-1:0]       nxt_cnt;
   logic [KNN_DIST_W-1:0]  nxt_dist;
   logic [LABEL_W-1:0]     nxt_label;

   knn_vote_count #(
      .K         (K),
      .DATA_INFO (DATA_INFO),
      .LABEL_W   (LABEL_W),
      .CNT_W     (CNT_W),
      .IDX_W     (IDX_W)
   ) u_count (
      .snap (snap_q),
      .idx  (idx_q),
      .cnt  (idx_cnt)
   );

   always_comb begin
      cur_entry = snap_q[int'(idx_q) * DATA_INFO +: DATA_INFO];

      // Strict comparisons in ascending index order keep the lower index on a full tie.
      take = eval_vld_q && eval_ok_q &&
             ((eval_cnt_q > best_cnt_q) ||
              ((eval_cnt_q == best_cnt_q) && (eval_dist_q < best_dist_q)));
      nxt_cnt   = take ? eval_cnt_q   : best_cnt_q;
      nxt_dist  = take ? eval_dist_q  : best_dist_q;
      nxt_label = take ? eval_label_q : best_label_q;

      state_d       = state_q;
      idx_d         = idx_q;
      snap_d        = snap_q;
      eval_vld_d    = eval_vld_q;
      eval_last_d   = eval_last_q;
      eval_ok_d     = eval_ok_q;
      eval_cnt_d    = eval_cnt_q;
      eval_dist_d   = eval_dist_q;
      eval_label_d  = eval_label_q;
      best_cnt_d    = best_cnt_q;
      best_dist_d   = best_dist_q;
      best_label_d  = best_label_q;
      busy_d        = busy_q;
      out_valid_d   = out_valid_q;
      class_label_d = class_label_q;
      votes_d       = votes_q;
      empty_d       = empty_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_SCAN;
               snap_d       = nb_list;
               idx_d        = '0;
               eval_vld_d   = 1'b0;
               eval_last_d  = 1'b0;
               best_cnt_d   = '0;
               best_dist_d  = '1;
               best_label_d = '0;
               busy_d       = 1'b1;
            end
         end
         ST_SCAN: begin
            eval_vld_d   = 1'b1;
            eval_last_d  = (idx_q == LAST_IDX);
            eval_ok_d    = (cur_entry[KNN_DIST_LSB +: KNN_DIST_W] != KNN_EMPTY_DIST);
            eval_cnt_d   = idx_cnt;
            eval_dist_d  = cur_entry[KNN_DIST_LSB +: KNN_DIST_W];
            eval_label_d = cur_entry[KNN_LABEL_LSB +: LABEL_W];
            if (idx_q != LAST_IDX) begin
               idx_d = idx_q + IDX_W'(1);
            end
            best_cnt_d   = nxt_cnt;
            best_dist_d  = nxt_dist;
            best_label_d = nxt_label;
            if (eval_vld_q && eval_last_q) begin
               state_d       = ST_DONE;
               idx_d         = '0;
               eval_vld_d    = 1'b0;
               out_valid_d   = 1'b1;
               class_label_d = nxt_label;
               votes_d       = nxt_cnt;
               empty_d       = (nxt_cnt == '0);
            end
         end
         ST_DONE: begin
            if (ack) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         snap_q        <= '0;
         eval_vld_q    <= 1'b0;
         eval_last_q   <= 1'b0;
         eval_ok_q     <= 1'b0;
         eval_cnt_q    <= '0;
         eval_dist_q   <= '0;
         eval_label_q  <= '0;
         best_cnt_q    <= '0;
         best_dist_q   <= '1;
         best_label_q  <= '0;
         busy_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         class_label_q <= '0;
         votes_q       <= '0;
         empty_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         snap_q        <= snap_d;
         eval_vld_q    <= eval_vld_d;
         eval_last_q   <= eval_last_d;
         eval_ok_q     <= eval_ok_d;
         eval_cnt_q    <= eval_cnt_d;
         eval_dist_q   <= eval_dist_d;
         eval_label_q  <= eval_label_d;
         best_cnt_q    <= best_cnt_d;
         best_dist_q   <= best_dist_d;
         best_label_q  <= best_label_d;
         busy_q        <= busy_d;
         out_valid_q   <= out_valid_d;
         class_label_q <= class_label_d;
         votes_q       <= votes_d;
         empty_q       <= empty_d;
      end
   end

   assign busy        = busy_q;
   assign out_valid   = out_valid_q;
   assign class_label = class_label_q;
   assign votes       = votes_q;
   assign empty       = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
//  tb_knn_vote
//  Directed scoreboard bench for knn_vote (K=4).
//  Revision: 1.0
// ============================================================================
module tb_knn_vote;

   localparam int K         = 4;
   localparam int DATA_INFO = 40;
   localparam int LABEL_W   = 8;
   localparam int CNT_W     = 3;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic                   ack;
   logic [K*DATA_INFO-1:0] nb_list;
   logic                   busy;
   logic                   out_valid;
   logic [LABEL_W-1:0]     class_label;
   logic [CNT_W-1:0]       votes;
   logic                   empty;

   typedef struct {
      logic [LABEL_W-1:0] lbl;
      logic [CNT_W-1:0]   vts;
      logic               emp;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [7:0]  lab[K];
   logic [31:0] dst[K];
   int          vecs = 0;
   int          errs = 0;
   int          stale;

   knn_vote #(
      .K         (K),
      .DATA_INFO (DATA_INFO),
      .LABEL_W   (LABEL_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .nb_list     (nb_list),
      .start       (start),
      .ack         (ack),
      .busy        (busy),
      .out_valid   (out_valid),
      .class_label (class_label),
      .votes       (votes),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: most votes, then smallest distance, then lowest index.
   function automatic exp_t model();
      exp_t        e;
      logic [31:0] bd;
      int          c;
      int          bc;
      e.lbl = '0;
      bc    = 0;
      bd    = '1;
      for (int i = 0; i < K; i++) begin
         if (dst[i] != 32'hFFFF_FFFF) begin
            c = 0;
            for (int j = 0; j < K; j++) begin
               if (dst[j] != 32'hFFFF_FFFF && lab[j] == lab[i]) c++;
            end
            if (c > bc || (c == bc && dst[i] < bd)) begin
               bc    = c;
               bd    = dst[i];
               e.lbl = lab[i];
            end
         end
      end
      e.vts = CNT_W'(bc);
      e.emp = (bc == 0);
      return e;
   endfunction

   task automatic set_list(input logic [7:0] l0, l1, l2, l3,
                           input logic [31:0] d0, d1, d2, d3);
      lab[0] = l0; lab[1] = l1; lab[2] = l2; lab[3] = l3;
      dst[0] = d0; dst[1] = d1; dst[2] = d2; dst[3] = d3;
      for (int i = 0; i < K; i++) begin
         nb_list[i*DATA_INFO +: DATA_INFO] = {dst[i], lab[i]};
      end
   endtask

   // Called just after a clock edge: start is sampled at the next edge.
   task automatic issue_start();
      start = 1'b1;
      sb.push_back(model());
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // n0 = edges already elapsed since the edge that sampled start.
   task automatic wait_result(input string tag, input int n0);
      int n;
      n = n0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (out_valid === 1'b1) break;
      end
      check({tag, "_latency"}, n, K + 1);
      check({tag, "_busy"}, busy, 1'b1);
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         check({tag, "_label"}, class_label, cur.lbl);
         check({tag, "_votes"}, votes, cur.vts);
         check({tag, "_empty"}, empty, cur.emp);
      end else begin
         check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
      end
   endtask

   // Leaves the bench just after the edge that returned the DUT to IDLE.
   task automatic do_ack(input string tag);
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      check({tag, "_ack_valid"}, out_valid, 1'b0);
      check({tag, "_ack_busy"}, busy, 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      ack     = 1'b0;
      nb_list = '0;
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_label", class_label, 8'd0);
      check("rst_votes", votes, 3'd0);
      check("rst_empty", empty, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Two-vote tie between labels 3 and 7; label 7 holds the nearest entry.
      set_list(8'd3, 8'd3, 8'd7, 8'd7, 32'd10, 32'd20, 32'd5, 32'd30);
      issue_start();
      wait_result("t_tie_dist", 0);
      check("t_tie_dist_label_const", class_label, 8'd7);
      do_ack("t_tie_dist");

      // Back-to-back start on the first IDLE cycle; a stray ack mid-scan is ignored.
      set_list(8'd1, 8'd2, 8'd2, 8'd2, 32'd1, 32'd40, 32'd50, 32'd60);
      issue_start();
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      wait_result("t_majority", 1);
      check("t_majority_votes_const", votes, 3'd3);
      do_ack("t_majority");

      set_list(8'd6, 8'd2, 8'd9, 8'd1, '1, '1, '1, '1);
      issue_start();
      wait_result("t_all_empty", 0);
      check("t_all_empty_const", empty, 1'b1);
      do_ack("t_all_empty");

      set_list(8'd4, 8'd9, 8'd4, 8'd9, 32'd8, 32'd8, 32'd8, 32'd8);
      issue_start();
      wait_result("t_full_tie", 0);
      check("t_full_tie_label_const", class_label, 8'd4);
      do_ack("t_full_tie");

      // Partially empty list: the nearer lone label beats nothing; empty slots never count.
      set_list(8'd5, 8'd8, 8'd8, 8'd5, '1, 32'd3, '1, 32'd2);
      issue_start();
      wait_result("t_partial", 0);
      do_ack("t_partial");

      // Snapshot isolation: list changes and start pulse during SCAN are ignored.
      set_list(8'd3, 8'd3, 8'd7, 8'd7, 32'd10, 32'd20, 32'd5, 32'd30);
      issue_start();
      set_list(8'd9, 8'd9, 8'd9, 8'd9, 32'd1, 32'd1, 32'd1, 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_result("t_snapshot", 1);
      repeat (10) begin
         @(negedge clk);
         check("t_hold_valid", out_valid, 1'b1);
         check("t_hold_label", class_label, 8'd7);
         check("t_hold_votes", votes, 3'd2);
         check("t_hold_empty", empty, 1'b0);
      end
      do_ack("t_snapshot");

      // Reset mid-scan aborts; no stale result after release.
      set_list(8'd1, 8'd1, 8'd2, 8'd3, 32'd4, 32'd4, 32'd4, 32'd4);
      issue_start();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t_abort_valid", out_valid, 1'b0);
      check("t_abort_busy", busy, 1'b0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale++;
      end
      check("t_abort_no_stale", stale, 0);
      @(posedge clk);
      #1;
      set_list(8'd5, 8'd5, 8'd5, 8'd5, 32'd7, 32'd3, 32'd9, 32'd1);
      issue_start();
      wait_result("t_after_rst", 0);
      check("t_after_rst_label_const", class_label, 8'd5);
      check("t_after_rst_votes_const", votes, 3'd4);
      do_ack("t_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire
